// File: rtl/usr_param_if.sv
// Bundle of the usr_param control, data and status signals.
// The master side drives the mode, serial and parallel inputs.
// The slave side (the shift register) returns q, the serial outs and the frame status.
interface usr_param_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             en;
  logic [2:0]       mode;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] pin;
  logic [WIDTH-1:0] q;
  logic             sout_l;
  logic             sout_r;
  logic [CW-1:0]    cnt;
  logic             frame_done;

  modport master (
    output en, mode, sin_l, sin_r, pin,
    input  q, sout_l, sout_r, cnt, frame_done
  );

  modport slave (
    input  en, mode, sin_l, sin_r, pin,
    output q, sout_l, sout_r, cnt, frame_done
  );
endinterface

// File: rtl/usr_param.sv
// Parametrised universal shift register.
// Supports hold, shift, rotate, parallel load and clear, all gated by a clock enable.
// A shift counter raises a one-cycle frame_done pulse after every WIDTH shift/rotate
// operations, so SIPO and PISO users know when a word is complete.
module usr_param #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input logic        clk,
  input logic        reset,
  usr_param_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fd_q, fd_d;
  logic             is_shift;

  // Next-state decode: the mode selects the data move; shifts and rotates advance the frame counter
  always_comb begin
    q_d      = q_q;
    cnt_d    = cnt_q;
    fd_d     = 1'b0;
    is_shift = 1'b0;
    if (bus.en) begin
      case (bus.mode)
        3'b001: begin q_d = {q_q[WIDTH-2:0], bus.sin_l};   is_shift = 1'b1; end
        3'b010: begin q_d = {bus.sin_r, q_q[WIDTH-1:1]};   is_shift = 1'b1; end
        3'b011: begin q_d = bus.pin;                       cnt_d = '0;      end
        3'b100: begin q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; is_shift = 1'b1; end
        3'b101: begin q_d = {q_q[0], q_q[WIDTH-1:1]};      is_shift = 1'b1; end
        3'b110: begin q_d = RST_VAL;                       cnt_d = '0;      end
        default: ; // hold, and the reserved code also holds
      endcase
    end
    // The counter wraps on the final shift of a frame, and that same edge raises the pulse
    if (is_shift) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        fd_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State register; reset overrides the enable and the mode
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q   <= RST_VAL;
      cnt_q <= '0;
      fd_q  <= 1'b0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
      fd_q  <= fd_d;
    end
  end

  assign bus.q          = q_q;
  assign bus.cnt        = cnt_q;
  assign bus.frame_done = fd_q;
  assign bus.sout_l     = q_q[WIDTH-1];
  assign bus.sout_r     = q_q[0];
endmodule

// File: tb/tb_usr_param.sv
// Scoreboard bench for usr_param: a WIDTH=8 and a WIDTH=4 instance share one stimulus stream.
// The stimulus process pushes expected results from an arithmetic model, and a monitor pops and compares them.
module tb_usr_param;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  usr_param_if #(.WIDTH(8)) bus8 ();
  usr_param_if #(.WIDTH(4)) bus4 ();

  usr_param #(.WIDTH(8)) u8 (.clk(clk), .reset(reset), .bus(bus8));
  usr_param #(.WIDTH(4), .RST_VAL(4'h6)) u4 (.clk(clk), .reset(reset), .bus(bus4));

  typedef struct { int q; int c; int f; } exp_t;
  exp_t sb8[$];
  exp_t sb4[$];

  int checks = 0;
  int errors = 0;

  // Reference model state, one entry per instance
  int wd[2] = '{8, 4};
  int rv[2] = '{0, 6};
  int mq[2];
  int mc[2];
  int mf[2];

  // Advance the model of instance k by one clock edge
  function automatic void model(int k, int rs, int e, int m, int sl, int sr, int p);
    int w    = wd[k];
    int mask = (1 << w) - 1;
    bit shifted = 0;
    mf[k] = 0;
    if (rs != 0) begin
      mq[k] = rv[k]; mc[k] = 0;
    end else if (e != 0) begin
      case (m)
        1: begin mq[k] = ((mq[k] << 1) | sl) & mask;                  shifted = 1; end
        2: begin mq[k] = (mq[k] >> 1) | (sr << (w - 1));              shifted = 1; end
        3: begin mq[k] = p & mask; mc[k] = 0; end
        4: begin mq[k] = ((mq[k] << 1) | (mq[k] >> (w - 1))) & mask;  shifted = 1; end
        5: begin mq[k] = (mq[k] >> 1) | ((mq[k] & 1) << (w - 1));     shifted = 1; end
        6: begin mq[k] = rv[k]; mc[k] = 0; end
        default: ;
      endcase
      if (shifted) begin
        mc[k] = mc[k] + 1;
        if (mc[k] == w) begin
          mc[k] = 0;
          mf[k] = 1;
        end
      end
    end
  endfunction

  // Drive one cycle of stimulus on both instances and push the expected results
  task automatic step(int rs, int e, int m, int sl, int sr, int p);
    exp_t x;
    @(negedge clk);
    reset = rs[0];
    bus8.en = e[0]; bus8.mode = m[2:0]; bus8.sin_l = sl[0]; bus8.sin_r = sr[0]; bus8.pin = p[7:0];
    bus4.en = e[0]; bus4.mode = m[2:0]; bus4.sin_l = sl[0]; bus4.sin_r = sr[0]; bus4.pin = p[3:0];
    model(0, rs, e, m, sl, sr, p);
    model(1, rs, e, m, sl, sr, p);
    x.q = mq[0]; x.c = mc[0]; x.f = mf[0]; sb8.push_back(x);
    x.q = mq[1]; x.c = mc[1]; x.f = mf[1]; sb4.push_back(x);
  endtask

  // Wait until the edge just driven has taken effect
  task automatic after();
    @(posedge clk);
    #2;
  endtask

  task automatic dchk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cmp(string tag, int k, int gq, int gc, int gf, int gsl, int gsr, exp_t e);
    int w   = wd[k];
    int esl = (e.q >> (w - 1)) & 1;
    int esr = e.q & 1;
    checks++;
    if (gq != e.q || gc != e.c || gf != e.f || gsl != esl || gsr != esr) begin
      errors++;
      $display("FAIL %s q=0x%0h/0x%0h cnt=%0d/%0d fd=%0d/%0d sl=%0d/%0d sr=%0d/%0d (got/exp) at %0t",
               tag, gq, e.q, gc, e.c, gf, e.f, gsl, esl, gsr, esr, $time);
    end
  endtask

  // Monitor: every edge produces a registered result, so pop one expectation per edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb8.size() > 0) begin
        e = sb8.pop_front();
        cmp("sb_w8", 0, int'(bus8.q), int'(bus8.cnt), int'(bus8.frame_done),
            int'(bus8.sout_l), int'(bus8.sout_r), e);
      end
      if (sb4.size() > 0) begin
        e = sb4.pop_front();
        cmp("sb_w4", 1, int'(bus4.q), int'(bus4.cnt), int'(bus4.frame_done),
            int'(bus4.sout_l), int'(bus4.sout_r), e);
      end
    end
  end

  initial begin
    int sipo[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    int piso[8] = '{0, 0, 1, 1, 1, 1, 0, 0};
    int rot[4]  = '{3, 6, 12, 9};
    int m, r, waited;
    reset = 1'b1;
    bus8.en = 0; bus8.mode = 0; bus8.sin_l = 0; bus8.sin_r = 0; bus8.pin = 0;
    bus4.en = 0; bus4.mode = 0; bus4.sin_l = 0; bus4.sin_r = 0; bus4.pin = 0;
    for (int k = 0; k < 2; k++) begin mq[k] = rv[k]; mc[k] = 0; mf[k] = 0; end

    // Reset with a dirty register
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 3, 0, 0, 'hA5);
    step(1, 1, 1, 1, 1, 0);
    after();
    dchk("rst_q", int'(bus8.q), 0);
    dchk("rst_cnt", int'(bus8.cnt), 0);
    dchk("rst_fd", int'(bus8.frame_done), 0);
    dchk("rst_q_w4", int'(bus4.q), 6);

    // SIPO left shift of eight serial bits
    for (int i = 0; i < 8; i++) step(0, 1, 1, sipo[i], 0, 0);
    after();
    dchk("sipo_q", int'(bus8.q), 'hB2);
    dchk("sipo_fd", int'(bus8.frame_done), 1);
    dchk("sipo_cnt", int'(bus8.cnt), 0);
    step(0, 1, 0, 0, 0, 0);
    after();
    dchk("sipo_fd_drop", int'(bus8.frame_done), 0);

    // PISO right: LSB first on sout_r
    step(0, 1, 3, 0, 0, 'h3C);
    after();
    for (int i = 0; i < 8; i++) begin
      dchk("piso_sout_r", int'(bus8.sout_r), piso[i]);
      dchk("piso_fd", int'(bus8.frame_done), 0);
      step(0, 1, 2, 0, 0, 0);
      after();
    end
    dchk("piso_q", int'(bus8.q), 0);
    dchk("piso_fd_end", int'(bus8.frame_done), 1);

    // Rotate left on the 4-bit instance
    step(0, 1, 3, 0, 0, 'h09);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 4, 0, 0, 0);
      after();
      dchk("rot_q", int'(bus4.q), rot[i]);
      dchk("rot_fd", int'(bus4.frame_done), (i == 3) ? 1 : 0);
    end
    step(0, 1, 4, 0, 0, 0);
    after();
    dchk("rot5_cnt", int'(bus4.cnt), 1);
    dchk("rot5_fd", int'(bus4.frame_done), 0);

    // Enable low, reserved and hold all keep q=0x5A, cnt=3
    step(0, 1, 3, 0, 0, 'h0B);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) step(0, 0, 1, 1, 1, 0);
      else       step(0, 1, (i == 3) ? 7 : 0, 1, 1, 0);
      after();
      dchk("hold_q", int'(bus8.q), 'h5A);
      dchk("hold_cnt", int'(bus8.cnt), 3);
      dchk("hold_fd", int'(bus8.frame_done), 0);
    end

    // Mid-frame clear restarts the count
    for (int i = 0; i < 5; i++) step(0, 1, 1, 1, 0, 0);
    step(0, 1, 6, 0, 0, 0);
    after();
    dchk("clr_q", int'(bus8.q), 0);
    dchk("clr_cnt", int'(bus8.cnt), 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 1, i & 1, 0, 0);
      after();
      dchk("abort_fd", int'(bus8.frame_done), (i == 7) ? 1 : 0);
    end

    // Randomised traffic, biased toward shifts and rotates so frames complete
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        r = $urandom_range(0, 3);
        m = (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 4 : 5;
      end else begin
        m = $urandom_range(0, 7);
      end
      step(($urandom_range(0, 79) == 0) ? 1 : 0,
           ($urandom_range(0, 9) != 0) ? 1 : 0,
           m, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 255));
    end
    step(0, 0, 0, 0, 0, 0);

    // Drain the scoreboards with a bounded wait
    waited = 0;
    while ((sb8.size() > 0 || sb4.size() > 0) && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #3;
    checks++;
    if (sb8.size() > 0 || sb4.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d/%0d required=0", sb8.size(), sb4.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/usr_param.md
Name: usr_param

Overview:
- Parametrised universal shift register for the shift-register library. Width is generic.
- Supports hold, logical shift left/right, rotate left/right, parallel load and clear, all under a clock enable.
- Adds a shift counter and a frame-done pulse so SIPO/PISO users know when a full word has been shifted in or out.
- Sits between serial links and parallel datapaths.

Parameters:
- WIDTH, 8: register width in bits. Legal range WIDTH >= 2.
- RST_VAL, {WIDTH{1'b0}}: value loaded into q on reset and on the clear mode.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  clock enable. When 0, the mode is ignored and all state holds.
- mode  input  3  operation select (see Behaviour).
- sin_l  input  1  serial input entering bit 0 on a left shift.
- sin_r  input  1  serial input entering bit WIDTH-1 on a right shift.
- pin  input  WIDTH  parallel load data.
- q  output  WIDTH  registered register contents (parallel out).
- sout_l  output  1  q[WIDTH-1], the serial out for left shifts. Combinational from q.
- sout_r  output  1  q[0], the serial out for right shifts. Combinational from q.
- cnt  output  $clog2(WIDTH+1)  shift/rotate operations since the last load, clear or frame wrap.
- frame_done  output  1  one-cycle registered pulse marking that WIDTH shift/rotate operations have completed.

Behaviour:
- Reset: if reset=1 at a rising edge, q<=RST_VAL, cnt<=0, frame_done<=0. Reset overrides en and mode. Reset mid-frame discards the partial count.
- All updates occur on the rising clk edge with one-cycle latency; the new q is visible the cycle after the edge.
- en=0: q and cnt hold, frame_done<=0.
- en=1, mode decode:
  - 000 hold: q unchanged, cnt unchanged.
  - 001 shift left: q<={q[WIDTH-2:0],sin_l}.
  - 010 shift right: q<={sin_r,q[WIDTH-1:1]}.
  - 011 parallel load: q<=pin, cnt<=0.
  - 100 rotate left: q<={q[WIDTH-2:0],q[WIDTH-1]}.
  - 101 rotate right: q<={q[0],q[WIDTH-1:1]}.
  - 110 clear: q<=RST_VAL, cnt<=0.
  - 111 reserved: behaves as hold. Never X-propagates.
- Counter (modes 001, 010, 100, 101 with en=1):
  - If cnt==WIDTH-1: cnt<=0 and frame_done<=1 in the same edge as the final shift. q then holds the completed word (SIPO) or the last data bit has just been presented on sout (PISO).
  - Otherwise cnt<=cnt+1.
  - cnt never reaches WIDTH; it wraps.
- frame_done is 0 on every edge not described above, including hold, load and clear. Back-to-back frames of continuous shifting give one pulse every WIDTH cycles.
- Direction changes mid-frame (e.g. left then right) still count toward the same frame. No direction tracking.
- A load or clear during a frame restarts the count and suppresses any pending pulse. A load on the cycle after frame_done is legal and standard for PISO.
- sout_l/sout_r reflect q before the next edge. PISO left: load, then sout_l presents pin[WIDTH-1] first, MSB first over WIDTH cycles.
- No combinational path from inputs to q/cnt/frame_done. sout_* depend only on q.

Test Plan:
- Reset with q dirty: WIDTH=8, load 0xA5, then reset=1 for one edge with en=1, mode=001 → q=0x00, cnt=0, frame_done=0 next cycle.
- SIPO left: WIDTH=8, en=1, mode=001, sin_l stream 1,0,1,1,0,0,1,0 → after 8th edge q=0xB2, frame_done=1 for exactly that cycle, cnt=0.
- PISO right: load pin=0x3C, then mode=010 with sin_r=0 for 8 cycles → sout_r sequence 0,0,1,1,1,1,0,0, q=0x00, frame_done pulses on the 8th shift.
- Rotate: WIDTH=4, load 0x9, mode=100 for 4 cycles → q=0x3,0x6,0xC,0x9; frame_done on the 4th edge; a 5th rotate gives cnt=1, no pulse.
- Enable/hold/reserved: WIDTH=8, q=0x5A, cnt=3; en=0 with mode=001 for 3 cycles, then en=1 with mode=111 and then mode=000 → q=0x5A, cnt=3 throughout, frame_done=0.
- Mid-frame abort: WIDTH=8, 5 left shifts, then mode=110 → q=RST_VAL, cnt=0; 8 further shifts give a single frame_done on the 8th, none earlier.
